// File: rtl/vec_pkg.sv
// Shared types and constants for the vector store path.
package vec_pkg;
  localparam int VLANES     = 5;
  localparam int VWIDTH     = 32;
  localparam int WORD_BYTES = 4;
  localparam int LANE_IDX_W = 3;

  typedef logic [LANE_IDX_W-1:0] lane_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } vst_state_t;
endpackage

// File: rtl/vec_next_lane.sv
// Lowest-set-bit priority encoder over a lane mask, plus an any-set flag.
module vec_next_lane
  import vec_pkg::*;
#(
  parameter int LANES = VLANES
) (
  input  logic [LANES-1:0] mask,
  output lane_idx_t        idx,
  output logic             any
);

  // Scan from the top so the last hit is the lowest set bit.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = lane_idx_t'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vec_store_serializer.sv
// Drains one captured 5-lane vector to the data-memory write port, one word per grant.
// Optional VSTORE_STRIDE_EN adds a per-request lane stride (default stride is one word).
module vec_store_serializer
  import vec_pkg::*;
#(
  parameter int LANES = VLANES,
  parameter int DW    = VWIDTH,
  parameter int AW    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    base_addr,
`ifdef VSTORE_STRIDE_EN
  input  logic [AW-1:0]    stride,
`endif
  input  logic [LANES-1:0] lane_mask,
  input  logic [LANES*DW-1:0] vec_data,
  output logic             mem_req,
  input  logic             mem_gnt,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  output logic             busy,
  output logic             done,
  output vst_state_t       dbg_state
);

  // Handshakes: a request transfers on in_valid & in_ready; a memory write
  // transfers on mem_req & mem_gnt, and mem_addr/mem_wdata hold until then.

  vst_state_t          state_q, state_d;
  logic [AW-1:0]       base_q;
  logic [LANES-1:0]    mask_q, enc_mask;
  logic [LANES*DW-1:0] vec_q, sel_vec;
  lane_idx_t           lane_q, enc_idx;
  logic                enc_any, accept, load_lane;
  logic [AW-1:0]       sel_base, sel_stride, lane_addr;
  logic [DW-1:0]       lane_data;

  assign in_ready  = (state_q == IDLE);
  assign mem_req   = (state_q == WRITE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;
  assign accept    = in_valid & in_ready;

`ifdef VSTORE_STRIDE_EN
  logic [AW-1:0] stride_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    stride_q <= '0;
    else if (accept) stride_q <= stride;
  end

  assign sel_stride = (state_q == IDLE) ? stride : stride_q;
`else
  assign sel_stride = AW'(WORD_BYTES);
`endif

  // In IDLE the encoder sees the incoming mask; in WRITE, the mask minus the lane being granted.
  assign enc_mask  = (state_q == IDLE) ? lane_mask : (mask_q & ~(LANES'(1) << lane_q));
  assign sel_base  = (state_q == IDLE) ? base_addr : base_q;
  assign sel_vec   = (state_q == IDLE) ? vec_data : vec_q;
  assign lane_addr = sel_base + AW'(enc_idx) * sel_stride;
  assign lane_data = sel_vec[enc_idx*DW +: DW];

  vec_next_lane #(.LANES(LANES)) u_next_lane (
    .mask (enc_mask),
    .idx  (enc_idx),
    .any  (enc_any)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load_lane = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          load_lane = enc_any;
          state_d   = enc_any ? WRITE : DONE;
        end
      end
      WRITE: begin
        if (mem_gnt) begin
          load_lane = enc_any;
          state_d   = enc_any ? WRITE : DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q    <= '0;
      mask_q    <= '0;
      vec_q     <= '0;
      lane_q    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if (accept) begin
        base_q <= base_addr;
        mask_q <= lane_mask;
        vec_q  <= vec_data;
      end else if (state_q == WRITE && mem_gnt) begin
        mask_q <= enc_mask;
      end
      if (load_lane) begin
        lane_q    <= enc_idx;
        mem_addr  <= lane_addr;
        mem_wdata <= lane_data;
      end
    end
  end

endmodule
